// File: rtl/alu_pkg.sv
// Shared types and encodings for the ALU command path.
package alu_pkg;

  localparam int unsigned ALU_DATA_W = 16;
  localparam int unsigned ALU_TAG_W  = 4;

  localparam logic [1:0] SEL_ARITH = 2'd0;
  localparam logic [1:0] SEL_LOGIC = 2'd1;
  localparam logic [1:0] SEL_SHIFT = 2'd2;
  localparam logic [1:0] SEL_PASS  = 2'd3;

  typedef struct packed {
    logic [3:0]            opcode;
    logic [ALU_DATA_W-1:0] op_a;
    logic [ALU_DATA_W-1:0] op_b;
    logic [ALU_TAG_W-1:0]  tag;
  } alu_cmd_t;

  typedef struct packed {
    logic [2:0] arith_ctrl;
    logic [2:0] logic_ctrl;
    logic [2:0] shift_ctrl;
    logic [1:0] result_sel;
    logic       no_wb;
  } alu_ex_ctrl_t;

  function automatic logic is_onehot16(input logic [15:0] v);
    return (v != '0) && ((v & (v - 16'd1)) == '0);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: storage, wrapping pointers and occupancy count.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_flush,
  input  logic                          i_push,
  input  logic                          i_pop,
  input  alu_cmd_t                      i_wdata,
  output alu_cmd_t                      o_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   o_count,
  output logic                          o_empty,
  output logic                          o_full
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  alu_cmd_t         r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Full/empty come from the count so pointers may wrap freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (i_push && !i_pop)      r_count <= r_count + CNT_W'(1);
      else if (!i_push && i_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(FIFO_DEPTH));

endmodule

// File: rtl/alu_cmd_issue.sv
// Command buffer and issue stage feeding the execute register from the FIFO head.
module alu_cmd_issue
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TAG_WIDTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [3:0]                  cmd_opcode,
  input  logic [DATA_WIDTH-1:0]       cmd_op_a,
  input  logic [DATA_WIDTH-1:0]       cmd_op_b,
  input  logic [TAG_WIDTH-1:0]        cmd_tag,
  output logic [3:0]                  dec_opcode,
  input  logic [15:0]                 dec_op_sel,
  input  logic [2:0]                  dec_arith_ctrl,
  input  logic [2:0]                  dec_logic_ctrl,
  input  logic [2:0]                  dec_shift_ctrl,
  input  logic [1:0]                  dec_result_sel,
  output logic                        ex_valid,
  input  logic                        ex_ready,
  output logic [DATA_WIDTH-1:0]       ex_op_a,
  output logic [DATA_WIDTH-1:0]       ex_op_b,
  output logic [TAG_WIDTH-1:0]        ex_tag,
  output logic [2:0]                  ex_arith_ctrl,
  output logic [2:0]                  ex_logic_ctrl,
  output logic [2:0]                  ex_shift_ctrl,
  output logic [1:0]                  ex_result_sel,
  output logic                        ex_no_wb,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        err_onehot
);

  alu_cmd_t     w_wr_cmd;
  alu_cmd_t     w_head;
  logic         w_empty;
  logic         w_full;
  logic         w_push;
  logic         w_issue;

  logic         r_run;
  logic         r_ex_valid;
  alu_cmd_t     r_ex_cmd;
  alu_ex_ctrl_t r_ex_ctrl;
  logic         r_err;

  assign w_wr_cmd = '{opcode: cmd_opcode, op_a: cmd_op_a, op_b: cmd_op_b, tag: cmd_tag};

  // r_run delays cmd_ready by one edge after reset release.
  assign cmd_ready = ~w_full & ~flush & r_run;
  assign w_push    = cmd_valid & cmd_ready;
  assign w_issue   = ~w_empty & (~r_ex_valid | ex_ready) & ~flush;

  alu_cmd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .i_push  (w_push),
    .i_pop   (w_issue),
    .i_wdata (w_wr_cmd),
    .o_rdata (w_head),
    .o_count (fifo_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign dec_opcode = w_empty ? 4'h0 : w_head.opcode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run      <= 1'b0;
      r_ex_valid <= 1'b0;
      r_ex_cmd   <= '0;
      r_ex_ctrl  <= '0;
      r_err      <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (flush) begin
        r_ex_valid <= 1'b0;
      end else if (w_issue) begin
        r_ex_valid           <= 1'b1;
        r_ex_cmd             <= w_head;
        r_ex_ctrl.arith_ctrl <= dec_arith_ctrl;
        r_ex_ctrl.logic_ctrl <= dec_logic_ctrl;
        r_ex_ctrl.shift_ctrl <= dec_shift_ctrl;
        r_ex_ctrl.result_sel <= dec_result_sel;
        r_ex_ctrl.no_wb      <= dec_op_sel[13] | dec_op_sel[14];
        if (!is_onehot16(dec_op_sel)) r_err <= 1'b1;
      end else if (ex_ready) begin
        r_ex_valid <= 1'b0;
      end
    end
  end

  assign ex_valid      = r_ex_valid;
  assign ex_op_a       = r_ex_cmd.op_a;
  assign ex_op_b       = r_ex_cmd.op_b;
  assign ex_tag        = r_ex_cmd.tag;
  assign ex_arith_ctrl = r_ex_ctrl.arith_ctrl;
  assign ex_logic_ctrl = r_ex_ctrl.logic_ctrl;
  assign ex_shift_ctrl = r_ex_ctrl.shift_ctrl;
  assign ex_result_sel = r_ex_ctrl.result_sel;
  assign ex_no_wb      = r_ex_ctrl.no_wb;
  assign err_onehot    = r_err;

endmodule
